// File: rtl/dff_ctrl_arb_if.sv
// Request/response bundle between requesters and the shared flip-flop arbiter.
interface dff_ctrl_arb_if;
  logic [3:0] req_valid;
  logic [7:0] req_op;
  logic [3:0] req_data;
  logic [3:0] ack;
  logic       rsp_q;

  modport master (output req_valid, req_op, req_data, input ack, rsp_q);
  modport slave  (input req_valid, req_op, req_data, output ack, rsp_q);
endinterface

// File: rtl/dff_ctrl_arb.sv
// Arbitrates four requesters onto one shared flip-flop: IDLE -> ISSUE -> WAIT -> RESP.
// Round robin by default; define DFF_ARB_FIXED_PRI_EN for fixed priority (lowest index wins).
module dff_ctrl_arb (
  input  logic           clk,
  input  logic           clear_in,
  dff_ctrl_arb_if.slave  req,
  output logic           busy,
  output logic [7:0]     op_count,
  output logic           dff_din,
  output logic           dff_preset,
  output logic           dff_clear,
  output logic           dff_enable,
  input  logic           dff_q
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e     state_q, state_d;
  logic [1:0] id_q;
  logic [3:0] ack_q, ack_d;
  logic       rsp_bit_q, rsp_bit_d;
  logic [7:0] cnt_q, cnt_d;
  logic       en_q, en_d, pre_q, pre_d, clr_q, clr_d, din_q, din_d;
`ifndef DFF_ARB_FIXED_PRI_EN
  logic [1:0] rr_q;
`endif

  logic [1:0] win, idx, gop;
  logic       found, gdat;

  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef DFF_ARB_FIXED_PRI_EN
      idx = 2'(i);
`else
      idx = rr_q + 2'(i);
`endif
      if (!found && req.req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign gop  = req.req_op[{win, 1'b0} +: 2];
  assign gdat = req.req_data[win];

  // State register plus the registered datapath/outputs
  always_ff @(posedge clk) begin
    if (clear_in) begin
      state_q   <= IDLE;
      id_q      <= 2'd0;
      ack_q     <= 4'd0;
      rsp_bit_q <= 1'b0;
      cnt_q     <= 8'd0;
      en_q      <= 1'b0;
      pre_q     <= 1'b0;
      clr_q     <= 1'b0;
      din_q     <= 1'b0;
`ifndef DFF_ARB_FIXED_PRI_EN
      rr_q      <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      rsp_bit_q <= rsp_bit_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      pre_q     <= pre_d;
      clr_q     <= clr_d;
      din_q     <= din_d;
      if (state_q == IDLE && found) begin
        id_q <= win;
`ifndef DFF_ARB_FIXED_PRI_EN
        rr_q <= win + 2'd1;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controls are decoded at the grant edge so they are plain flops during ISSUE
  always_comb begin
    busy      = (state_q != IDLE);
    en_d      = 1'b0;
    pre_d     = 1'b0;
    clr_d     = 1'b0;
    din_d     = 1'b0;
    ack_d     = 4'd0;
    rsp_bit_d = rsp_bit_q;
    cnt_d     = cnt_q;
    if (state_q == IDLE && found) begin
      case (gop)
        2'b00: begin en_d = 1'b1; din_d = gdat;   end
        2'b01: pre_d = 1'b1;
        2'b10: clr_d = 1'b1;
        default: begin en_d = 1'b1; din_d = ~dff_q; end
      endcase
    end
    if (state_q == WAIT) begin
      rsp_bit_d   = dff_q;
      ack_d[id_q] = 1'b1;
    end
    if (state_q == RESP && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  assign req.ack    = ack_q;
  assign req.rsp_q  = rsp_bit_q;
  assign op_count   = cnt_q;
  // A reset mid-ISSUE must not let the write reach the flip-flop on that edge
  assign dff_enable = en_q  & ~clear_in;
  assign dff_preset = pre_q & ~clear_in;
  assign dff_clear  = clr_q & ~clear_in;
  assign dff_din    = din_q & ~clear_in;

endmodule

// File: doc/dff_ctrl_arb.md
DFF_CTRL_ARB -- requirements
Module: dff_ctrl_arb

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 The block SHALL have port clear_in, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port req_valid, input, 4 bits: per-requester request, held high until the matching ack.
REQ-004 The block SHALL have port req_op, input, 8 bits (2 per requester): 00 load, 01 set, 10 clear, 11 toggle.
REQ-005 The block SHALL have port req_data, input, 4 bits: per-requester load value; used only by the load op.
REQ-006 The block SHALL have port ack, output, 4 bits: one-cycle completion pulse per requester.
REQ-007 The block SHALL have port rsp_q, output, 1 bit: stored bit after the granted op; valid while any ack bit is high.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port op_count, output, 8 bits: number of completed ops, saturating.
REQ-010 The block SHALL have ports dff_din, dff_preset, dff_clear and dff_enable, all outputs, 1 bit each: registered controls to the shared flip-flop.
REQ-011 The block SHALL have port dff_q, input, 1 bit: output of the shared flip-flop.

Function
REQ-012 The block SHALL use a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-013 IDLE: when any req_valid bit is high, the block SHALL select a winner, latch its id, op and data, and move to ISSUE on the next edge.
REQ-014 ISSUE: the block SHALL drive exactly one cycle of flip-flop control, then move to WAIT.
  - load: dff_enable=1, dff_din=data.
  - set: dff_preset=1.
  - clear: dff_clear=1.
  - toggle: dff_enable=1, dff_din=inverse of dff_q sampled in the IDLE grant cycle.
REQ-015 WAIT: all dff_* controls SHALL be 0; the block SHALL register dff_q into rsp_q, then move to RESP.
REQ-016 RESP: the block SHALL pulse ack[id] for exactly one cycle, increment op_count, then return to IDLE.
REQ-017 Latency: a request sampled in the IDLE cycle at edge N SHALL produce its ack in the cycle after edge N+3; minimum spacing between acks is 4 cycles.
REQ-018 Round-robin arbitration: the search SHALL start at pointer rr_ptr (2 bits), and after each grant rr_ptr SHALL become winner+1, modulo 4 (wrap from 3 to 0).
REQ-019 Only one of dff_preset, dff_clear and dff_enable SHALL be high in any cycle; all are 0 outside ISSUE.
REQ-020 A req_valid that drops after the grant SHALL NOT abort the transaction; the ack SHALL still pulse.
REQ-021 After its ack, a requester SHALL NOT be re-granted unless its req_valid is high in a later IDLE cycle.
REQ-022 op_count SHALL saturate at 255 with no wrap.
REQ-023 req_op and req_data SHALL be ignored outside the IDLE grant cycle.

Reset
REQ-024 When clear_in=1 at an edge, the block SHALL set:
  - state=IDLE, rr_ptr=0
  - ack=0, rsp_q=0, busy=0, op_count=0
  - all dff_* outputs=0
REQ-025 A reset during ISSUE, WAIT or RESP SHALL abandon the op with no ack; the flip-flop control SHALL drop in that same cycle.

Configuration
REQ-026 With macro DFF_ARB_FIXED_PRI_EN defined, arbitration SHALL be fixed priority (lowest index wins) and rr_ptr SHALL be absent.
REQ-027 Without DFF_ARB_FIXED_PRI_EN, arbitration SHALL be round robin per REQ-018.

Verification
REQ-028 The bench SHALL cover a load: reset, then req_valid=0001, op=00, data[0]=1 -> dff_enable=1 and dff_din=1 for one cycle, then ack=0001 with rsp_q=1 exactly 4 cycles after the request is sampled.
REQ-029 The bench SHALL cover contention: req_valid=1111 held with all ops=toggle from q=0 -> acks in order 0001, 0010, 0100, 1000, 0001, with rsp_q alternating 1,0,1,0,1; with DFF_ARB_FIXED_PRI_EN defined, ack stays 0001.
REQ-030 The bench SHALL cover set then clear: requester 2 set, then requester 3 clear -> dff_preset pulses then dff_clear pulses; rsp_q is 1 then 0; no cycle has two controls high.
REQ-031 The bench SHALL cover reset mid-operation: clear_in=1 in the WAIT cycle -> no ack, busy=0, op_count=0 and rr_ptr=0 on the next cycle.
REQ-032 The bench SHALL cover saturation: 260 completed ops -> op_count reads 255.
REQ-033 The bench SHALL cover request withdrawal: req_valid[1] dropped in the ISSUE cycle -> ack[1] still pulses in the RESP cycle.
